mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit_md_div_step.sv | 23 ++
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and word sizes.
package mul_div_unit_pkg;

    localparam int unsigned MD_OP_LENGTH = 3;
    localparam int unsigned WORD_WIDTH   = 32;

    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

    localparam logic [MD_OP_LENGTH-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_LENGTH-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_LENGTH-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_LENGTH-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_LENGTH-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_LENGTH-1:0] MD_MTLO  = 3'd5;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [WORD_WIDTH-1:0] cond_neg(input logic [WORD_WIDTH-1:0] w,
                                                       input logic                  neg);
        return neg ? (~w + 1'b1) : w;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic                    mdStartE;
    logic [MD_OP_LENGTH-1:0] mdOpE;
    logic [WORD_WIDTH-1:0]   SrcA;
    logic [WORD_WIDTH-1:0]   SrcB;
    logic                    flushE;
    logic                    mdBusyE;
    logic                    mdDoneE;
    logic [WORD_WIDTH-1:0]   hiOut;
    logic [WORD_WIDTH-1:0]   loOut;

    modport master (
        output mdStartE, mdOpE, SrcA, SrcB, flushE,
        input  mdBusyE, mdDoneE, hiOut, loOut
    );

    modport slave (
        input  mdStartE, mdOpE, SrcA, SrcB, flushE,
        output mdBusyE, mdDoneE, hiOut, loOut
    );

endinterface

// File: rtl/mul_div_unit_md_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module mul_div_unit_md_div_step
    import mul_div_unit_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] rem_i,
    input  logic                  dividend_bit_i,
    input  logic [WORD_WIDTH-1:0] divisor_i,
    output logic [WORD_WIDTH-1:0] rem_o,
    output logic                  quo_bit_o
);

    logic [WORD_WIDTH:0] shifted;
    logic [WORD_WIDTH:0] diff;

    // Borrow out of the wide subtract means the divisor did not fit.
    always_comb begin
        shifted   = {rem_i, dividend_bit_i};
        diff      = shifted - {1'b0, divisor_i};
        quo_bit_o = ~diff[WORD_WIDTH];
        rem_o     = quo_bit_o ? diff[WORD_WIDTH-1:0] : shifted[WORD_WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO registers.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave md
);

    localparam int unsigned DW = 2 * WORD_WIDTH;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e                state_q;
    logic [4:0]            cnt_q;
    logic [DW-1:0]         work_q;     // {acc/remainder, multiplier/quotient}
    logic [WORD_WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
    logic                  neg_q;      // negate product/quotient at commit
    logic                  rem_neg_q;  // negate remainder at commit
    logic                  is_div_q;
    logic                  busy_q;
    logic                  done_q;
    logic [WORD_WIDTH-1:0] hi_q;
    logic [WORD_WIDTH-1:0] lo_q;

    logic                  op_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [WORD_WIDTH-1:0] a_mag;
    logic [WORD_WIDTH-1:0] b_mag;
    logic [WORD_WIDTH:0]   mul_sum;
    logic [DW-1:0]         mul_next;
    logic [DW-1:0]         div_next;
    logic [WORD_WIDTH-1:0] div_rem;
    logic                  div_bit;
    logic [DW-1:0]         prod_fix;
    logic [WORD_WIDTH-1:0] quo_fix;
    logic [WORD_WIDTH-1:0] rem_fix;

    // Operand magnitudes and signs for the requested operation.
    always_comb begin
        op_signed = (md.mdOpE == MD_MULT) || (md.mdOpE == MD_DIV);
        a_neg     = op_signed & md.SrcA[WORD_WIDTH-1];
        b_neg     = op_signed & md.SrcB[WORD_WIDTH-1];
        a_mag     = cond_neg(md.SrcA, a_neg);
        b_mag     = cond_neg(md.SrcB, b_neg);
    end

    mul_div_unit_md_div_step u_div_step (
        .rem_i          (work_q[DW-1:WORD_WIDTH]),
        .dividend_bit_i (work_q[WORD_WIDTH-1]),
        .divisor_i      (opnd_q),
        .rem_o          (div_rem),
        .quo_bit_o      (div_bit)
    );

    // Next iteration values and sign-corrected results for the DONE commit.
    always_comb begin
        mul_sum  = {1'b0, work_q[DW-1:WORD_WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[WORD_WIDTH-1:1]};
        div_next = {div_rem, work_q[WORD_WIDTH-2:0], div_bit};
        prod_fix = neg_q ? (~work_q + 1'b1) : work_q;
        quo_fix  = cond_neg(work_q[WORD_WIDTH-1:0], neg_q);
        rem_fix  = cond_neg(work_q[DW-1:WORD_WIDTH], rem_neg_q);
    end

    // Control FSM, working registers and HI/LO; reset wins over flush and start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            work_q    <= '0;
            opnd_q    <= ZERO_WORD;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_div_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= ZERO_WORD;
            lo_q      <= ZERO_WORD;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (md.mdStartE && !md.flushE) begin
                        cnt_q <= '0;
                        case (md.mdOpE)
                            MD_MTHI: hi_q <= md.SrcA;
                            MD_MTLO: lo_q <= md.SrcA;
                            MD_MULT, MD_MULTU: begin
                                state_q  <= StMul;
                                busy_q   <= 1'b1;
                                work_q   <= {ZERO_WORD, b_mag};
                                opnd_q   <= a_mag;
                                neg_q    <= a_neg ^ b_neg;
                                is_div_q <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                busy_q   <= 1'b1;
                                is_div_q <= 1'b1;
                                if (md.SrcB == ZERO_WORD) begin
                                    // Preload the fixed divide-by-zero result, no correction.
                                    state_q   <= StDone;
                                    done_q    <= 1'b1;
                                    work_q    <= {md.SrcA, ~ZERO_WORD};
                                    neg_q     <= 1'b0;
                                    rem_neg_q <= 1'b0;
                                end else begin
                                    state_q   <= StDiv;
                                    work_q    <= {ZERO_WORD, a_mag};
                                    opnd_q    <= b_mag;
                                    neg_q     <= a_neg ^ b_neg;
                                    rem_neg_q <= a_neg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StMul, StDiv: begin
                    if (md.flushE) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        work_q <= (state_q == StMul) ? mul_next : div_next;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (!md.flushE) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[DW-1:WORD_WIDTH];
                            lo_q <= prod_fix[WORD_WIDTH-1:0];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A flush during DONE cancels the commit, so it also suppresses the done pulse.
    assign md.mdDoneE = done_q & ~md.flushE;
    assign md.mdBusyE = busy_q;
    assign md.hiOut   = hi_q;
    assign md.loOut   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

    mul_div_unit_if md_if ();

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted operation, straight from the arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] r;
        logic [63:0]        ua;
        logic [63:0]        ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        exp_lat = 33;
        case (op)
            MD_MULT:  begin r = sa * sb; exp_hi = r[63:32]; exp_lo = r[31:0]; end
            MD_MULTU: begin r = ua * ub; exp_hi = r[63:32]; exp_lo = r[31:0]; end
            MD_DIV, MD_DIVU: begin
                if (b == 32'h0) begin
                    exp_hi  = a;
                    exp_lo  = 32'hFFFFFFFF;
                    exp_lat = 1;
                end else if (op == MD_DIV) begin
                    r = sa / sb; exp_lo = r[31:0];
                    r = sa % sb; exp_hi = r[31:0];
                end else begin
                    r = ua / ub; exp_lo = r[31:0];
                    r = ua % ub; exp_hi = r[31:0];
                end
            end
            MD_MTHI: begin exp_hi = a; exp_lat = 0; end
            default: begin exp_lo = a; exp_lat = 0; end
        endcase
    endtask

    // Issue one operation and check timing, HI/LO visibility and final result.
    task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          waits;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, a, b);
        @(negedge clk);
        md_if.mdStartE = 1'b1;
        md_if.mdOpE    = op;
        md_if.SrcA     = a;
        md_if.SrcB     = b;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        if (exp_lat == 0) begin
            check({tag, " mt_hi"}, {32'h0, md_if.hiOut}, {32'h0, exp_hi});
            check({tag, " mt_lo"}, {32'h0, md_if.loOut}, {32'h0, exp_lo});
            check({tag, " mt_busy"}, {63'h0, md_if.mdBusyE}, 64'h0);
            return;
        end
        check({tag, " busy"}, {63'h0, md_if.mdBusyE}, 64'h1);
        waits = 0;
        while (!md_if.mdDoneE && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check({tag, " latency"}, 64'(waits), 64'(exp_lat - 1));
        check({tag, " hidden"}, {md_if.hiOut, md_if.loOut}, {old_hi, old_lo});
        @(negedge clk);
        check({tag, " hilo"}, {md_if.hiOut, md_if.loOut}, {exp_hi, exp_lo});
        check({tag, " pulse"}, {62'h0, md_if.mdDoneE, md_if.mdBusyE}, 64'h0);
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int          n;
        logic        seen_done;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n          = 1'b0;
        md_if.mdStartE = 1'b0;
        md_if.mdOpE    = 3'd0;
        md_if.SrcA     = 32'h0;
        md_if.SrcB     = 32'h0;
        md_if.flushE   = 1'b0;
        exp_hi         = 32'h0;
        exp_lo         = 32'h0;
        exp_lat        = 0;

        @(negedge clk);
        check("reset", {md_if.hiOut, md_if.loOut}, 64'h0);
        check("reset ctl", {62'h0, md_if.mdBusyE, md_if.mdDoneE}, 64'h0);
        rst_n = 1'b1;

        exec(MD_MULT, 32'hFFFFFFFE, 32'h00000003, "mult_neg");
        check("mult_neg const", {md_if.hiOut, md_if.loOut}, 64'hFFFFFFFF_FFFFFFFA);
        exec(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        check("multu_max const", {md_if.hiOut, md_if.loOut}, 64'hFFFFFFFE_00000001);
        exec(MD_DIV, 32'hFFFFFFF9, 32'h00000002, "div_neg");
        check("div_neg const", {md_if.hiOut, md_if.loOut}, 64'hFFFFFFFF_FFFFFFFD);
        exec(MD_DIVU, 32'd7, 32'd2, "divu_7_2");
        check("divu_7_2 const", {md_if.hiOut, md_if.loOut}, 64'h00000001_00000003);
        exec(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        check("div_ovf const", {md_if.hiOut, md_if.loOut}, 64'h00000000_80000000);
        exec(MD_DIVU, 32'h12345678, 32'h0, "divu_zero");
        check("divu_zero const", {md_if.hiOut, md_if.loOut}, 64'h12345678_FFFFFFFF);

        // Flush in MUL at cycle 10: back to IDLE, nothing committed.
        @(negedge clk);
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_MULT; md_if.SrcA = 32'd5; md_if.SrcB = 32'd7;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin @(negedge clk); seen_done |= md_if.mdDoneE; end
        md_if.flushE = 1'b1;
        @(negedge clk);
        md_if.flushE = 1'b0;
        check("flush busy", {63'h0, md_if.mdBusyE}, 64'h0);
        repeat (40) begin @(negedge clk); seen_done |= md_if.mdDoneE; end
        check("flush no done", {63'h0, seen_done}, 64'h0);
        check("flush hilo", {md_if.hiOut, md_if.loOut}, {exp_hi, exp_lo});

        // Second start while busy must not restart or retarget the operation.
        model(MD_MULTU, 32'd3, 32'd4);
        @(negedge clk);
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_MULTU; md_if.SrcA = 32'd3; md_if.SrcB = 32'd4;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_DIVU; md_if.SrcA = 32'd100; md_if.SrcB = 32'd3;
        @(negedge clk);
        n++;
        md_if.mdStartE = 1'b0;
        while (!md_if.mdDoneE && n < 60) begin @(negedge clk); n++; end
        check("busy start latency", 64'(n), 64'd33);
        @(negedge clk);
        check("busy start hilo", {md_if.hiOut, md_if.loOut}, {exp_hi, exp_lo});

        // Flush during DONE (divide-by-zero path) drops the commit and the pulse.
        @(negedge clk);
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_DIVU; md_if.SrcA = 32'hCAFE; md_if.SrcB = 32'h0;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        md_if.flushE   = 1'b1;
        #1;
        check("done flush pulse", {63'h0, md_if.mdDoneE}, 64'h0);
        @(negedge clk);
        md_if.flushE = 1'b0;
        check("done flush hilo", {md_if.hiOut, md_if.loOut}, {exp_hi, exp_lo});
        check("done flush busy", {63'h0, md_if.mdBusyE}, 64'h0);

        // Flush in IDLE blocks an MTHI in the same cycle.
        @(negedge clk);
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_MTHI; md_if.SrcA = 32'h11111111;
        md_if.flushE   = 1'b1;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        md_if.flushE   = 1'b0;
        check("idle flush", {md_if.hiOut, md_if.loOut}, {exp_hi, exp_lo});

        // Back-to-back MTHI / MTLO.
        @(negedge clk);
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_MTHI; md_if.SrcA = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi", {32'h0, md_if.hiOut}, 64'hDEADBEEF);
        check("mthi busy", {63'h0, md_if.mdBusyE}, 64'h0);
        md_if.mdOpE = MD_MTLO; md_if.SrcA = 32'h0BADF00D;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        check("mtlo", {md_if.hiOut, md_if.loOut}, 64'hDEADBEEF_0BADF00D);
        check("mtlo busy", {63'h0, md_if.mdBusyE}, 64'h0);

        // Reset in the middle of a DIV.
        @(negedge clk);
        md_if.mdStartE = 1'b1; md_if.mdOpE = MD_DIV; md_if.SrcA = 32'd1000; md_if.SrcB = 32'd7;
        @(negedge clk);
        md_if.mdStartE = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid reset hilo", {md_if.hiOut, md_if.loOut}, 64'h0);
        check("mid reset ctl", {62'h0, md_if.mdBusyE, md_if.mdDoneE}, 64'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        seen_done = 1'b0;
        repeat (36) begin @(negedge clk); seen_done |= md_if.mdDoneE; end
        check("mid reset no done", {63'h0, seen_done}, 64'h0);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = pick();
            rb  = pick();
            exec(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
